// File: rtl/set_assoc_cache_sim.sv
// Tag-only N-way set-associative cache model with true-LRU replacement, flush,
// and saturating hit/miss/eviction statistics for trace-driven simulation.
module set_assoc_cache_sim #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32*1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_ready,
    input  logic [31:0] mem_addr,
    input  logic        flush,
    output logic        busy,
    output logic        found_in_cache,
    output logic        updated,
    output logic [31:0] cache_hit_count,
    output logic [31:0] cache_miss_count,
    output logic [31:0] evict_count
);
    localparam int SETS  = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
    localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int AGE_W = (WAY > 1) ? $clog2(WAY) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, UPDATE = 2'd2} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) sat_inc = v;
        else                    sat_inc = v + 32'd1;
    endfunction

    state_t             state_r, state_s;
    logic [TAG_W-1:0]   tag_mem_r   [SETS][WAY];
    logic [AGE_W-1:0]   age_mem_r   [SETS][WAY];
    logic [WAY-1:0]     valid_mem_r [SETS];
    logic [TAG_W-1:0]   req_tag_r;
    logic [IDX_W-1:0]   req_idx_r;
    logic               hit_r, victim_valid_r;
    logic [AGE_W-1:0]   hit_way_r, victim_r;
    logic               hit_s, victim_valid_s, have_invalid_s;
    logic [AGE_W-1:0]   hit_way_s, victim_s, acc_way_s, old_age_s;
    logic [AGE_W-1:0]   new_age_s   [WAY];
    logic               busy_r, found_r, updated_r;
    logic [31:0]        hit_cnt_r, miss_cnt_r, evict_cnt_r;
    logic               unused_off_s;

    assign unused_off_s = ^mem_addr[OFF_W-1:0];

    // Next-state logic: flush in IDLE takes priority over a new request
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!flush && trace_ready) state_s = LOOKUP;
                else                       state_s = IDLE;
            end
            LOOKUP:  state_s = UPDATE;
            UPDATE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Parallel tag compare and victim choice for the latched set
    always_comb begin
        hit_s          = 1'b0;
        hit_way_s      = '0;
        victim_s       = '0;
        have_invalid_s = 1'b0;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (valid_mem_r[req_idx_r][w] && (tag_mem_r[req_idx_r][w] == req_tag_r)) begin
                hit_s     = 1'b1;
                hit_way_s = AGE_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            // Descending scan leaves the lowest-index invalid way selected
            if (!valid_mem_r[req_idx_r][w]) begin
                have_invalid_s = 1'b1;
                victim_s       = AGE_W'(w);
            end else begin
                have_invalid_s = have_invalid_s;
            end
        end
        if (!have_invalid_s) begin
            for (int w = 0; w < WAY; w++) begin
                if (age_mem_r[req_idx_r][w] == AGE_W'(WAY - 1)) victim_s = AGE_W'(w);
                else                                            victim_s = victim_s;
            end
        end else begin
            victim_s = victim_s;
        end
        victim_valid_s = ~have_invalid_s;
    end

    // LRU ages after touching the accessed way: younger ways age by one
    always_comb begin
        acc_way_s = hit_r ? hit_way_r : victim_r;
        old_age_s = age_mem_r[req_idx_r][acc_way_s];
        for (int w = 0; w < WAY; w++) begin
            if (AGE_W'(w) == acc_way_s)                   new_age_s[w] = '0;
            else if (age_mem_r[req_idx_r][w] < old_age_s) new_age_s[w] = age_mem_r[req_idx_r][w] + AGE_W'(1);
            else                                          new_age_s[w] = age_mem_r[req_idx_r][w];
        end
    end

    // Control, request latch, lookup results, pulses and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            req_tag_r      <= '0;
            req_idx_r      <= '0;
            hit_r          <= 1'b0;
            hit_way_r      <= '0;
            victim_r       <= '0;
            victim_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            found_r        <= 1'b0;
            updated_r      <= 1'b0;
            hit_cnt_r      <= 32'd0;
            miss_cnt_r     <= 32'd0;
            evict_cnt_r    <= 32'd0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_r != IDLE) || (state_s == LOOKUP);
            found_r   <= (state_r == UPDATE) && hit_r;
            updated_r <= (state_r == UPDATE) && !hit_r;
            if (state_r == IDLE && state_s == LOOKUP) begin
                req_tag_r <= mem_addr[31:IDX_W+OFF_W];
                req_idx_r <= mem_addr[IDX_W+OFF_W-1:OFF_W];
            end
            if (state_r == LOOKUP) begin
                hit_r          <= hit_s;
                hit_way_r      <= hit_way_s;
                victim_r       <= victim_s;
                victim_valid_r <= victim_valid_s;
            end
            if (state_r == UPDATE) begin
                if (hit_r) begin
                    hit_cnt_r <= sat_inc(hit_cnt_r);
                end else begin
                    miss_cnt_r <= sat_inc(miss_cnt_r);
                    if (victim_valid_r) evict_cnt_r <= sat_inc(evict_cnt_r);
                end
            end
        end
    end

    // Tag, valid and age storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem_r[s] <= '0;
                for (int w = 0; w < WAY; w++) begin
                    tag_mem_r[s][w] <= '0;
                    age_mem_r[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            if (state_r == IDLE && flush) begin
                for (int s = 0; s < SETS; s++) valid_mem_r[s] <= '0;
            end
            if (state_r == UPDATE) begin
                for (int w = 0; w < WAY; w++) age_mem_r[req_idx_r][w] <= new_age_s[w];
                if (!hit_r) begin
                    tag_mem_r[req_idx_r][victim_r]   <= req_tag_r;
                    valid_mem_r[req_idx_r][victim_r] <= 1'b1;
                end
            end
        end
    end

    assign busy             = busy_r;
    assign found_in_cache   = found_r;
    assign updated          = updated_r;
    assign cache_hit_count  = hit_cnt_r;
    assign cache_miss_count = miss_cnt_r;
    assign evict_count      = evict_cnt_r;
endmodule

// File: tb/tb_set_assoc_cache_sim.sv
// Directed bench for set_assoc_cache_sim: 2-way, 16-byte blocks, 2 sets.
module tb_set_assoc_cache_sim;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_ready = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic        flush = 1'b0;
    logic        busy, found_in_cache, updated;
    logic [31:0] cache_hit_count, cache_miss_count, evict_count;

    int compared = 0;
    int mismatched = 0;
    int both_cnt = 0;
    int found_seen = 0;
    int upd_seen = 0;
    int mono_err = 0;
    logic [31:0] prev_hit = 32'd0, prev_miss = 32'd0, prev_evict = 32'd0;

    localparam logic [5:0] EXP_MISS = {4'd2, 1'b0, 1'b1};
    localparam logic [5:0] EXP_HIT  = {4'd2, 1'b1, 1'b0};

    set_assoc_cache_sim #(.WAY(2), .BLOCK_SIZE_BYTE(16), .CACHE_SIZE_BYTE(64)) dut (
        .clk(clk), .rst_n(rst_n), .trace_ready(trace_ready), .mem_addr(mem_addr),
        .flush(flush), .busy(busy), .found_in_cache(found_in_cache), .updated(updated),
        .cache_hit_count(cache_hit_count), .cache_miss_count(cache_miss_count),
        .evict_count(evict_count)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping and counter monotonicity, sampled mid-cycle
    always @(negedge clk) begin
        if (found_in_cache && updated) both_cnt++;
        if (found_in_cache) found_seen++;
        if (updated) upd_seen++;
        if (rst_n) begin
            if (cache_hit_count < prev_hit || cache_miss_count < prev_miss || evict_count < prev_evict) mono_err++;
            prev_hit = cache_hit_count; prev_miss = cache_miss_count; prev_evict = evict_count;
        end else begin
            prev_hit = 32'd0; prev_miss = 32'd0; prev_evict = 32'd0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; trace_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request; res = {latency in edges after acceptance, hit pulse, updated pulse}
    task automatic access(input logic [31:0] a, output logic [5:0] res);
        logic [3:0] lat;
        logic h, u;
        lat = 4'd15; h = 1'b0; u = 1'b0;
        @(negedge clk);
        mem_addr = a; trace_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trace_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (lat == 4'd15 && (found_in_cache || updated)) begin
                lat = 4'(k); h = found_in_cache; u = updated;
            end
        end
        res = {lat, h, u};
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        compared++;
        if ({busy, found_in_cache, updated, cache_hit_count, cache_miss_count, evict_count} !== 99'd0) begin
            mismatched++;
            $display("FAIL reset_outputs got busy=%b f=%b u=%b h=%0d m=%0d e=%0d required all 0",
                     busy, found_in_cache, updated, cache_hit_count, cache_miss_count, evict_count);
        end
    endtask

    task automatic check_counts(input string name, input int h, input int m, input int e);
        compared++;
        if (cache_hit_count !== 32'(h) || cache_miss_count !== 32'(m) || evict_count !== 32'(e)) begin
            mismatched++;
            $display("FAIL %s got h=%0d m=%0d e=%0d required h=%0d m=%0d e=%0d",
                     name, cache_hit_count, cache_miss_count, evict_count, h, m, e);
        end
    endtask

    task automatic test_hit_after_miss();
        logic [5:0] r;
        do_reset();
        access(32'h00, r);
        compared++;
        if (r !== EXP_MISS) begin mismatched++; $display("FAIL t1_0x00 got %b required %b", r, EXP_MISS); end
        check_counts("t1_after_miss", 0, 1, 0);
        access(32'h04, r);
        compared++;
        if (r !== EXP_HIT) begin mismatched++; $display("FAIL t1_0x04 got %b required %b", r, EXP_HIT); end
        check_counts("t1_after_hit", 1, 1, 0);
    endtask

    task automatic test_eviction();
        logic [31:0] addrs [4] = '{32'h00, 32'h20, 32'h40, 32'h00};
        logic [5:0] r;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            access(addrs[i], r);
            compared++;
            if (r !== EXP_MISS) begin mismatched++; $display("FAIL t2_access%0d got %b required %b", i, r, EXP_MISS); end
            if (i == 2) check_counts("t2_after_0x40", 0, 3, 1);
        end
        check_counts("t2_final", 0, 4, 2);
    endtask

    task automatic test_lru_order();
        logic [31:0] addrs [6] = '{32'h00, 32'h20, 32'h00, 32'h40, 32'h00, 32'h20};
        logic [5:0]  exps  [6] = '{EXP_MISS, EXP_MISS, EXP_HIT, EXP_MISS, EXP_HIT, EXP_MISS};
        logic [5:0] r;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            access(addrs[i], r);
            compared++;
            if (r !== exps[i]) begin mismatched++; $display("FAIL t3_access%0d got %b required %b", i, r, exps[i]); end
        end
        check_counts("t3_final", 2, 4, 2);
    endtask

    task automatic test_sets();
        logic [5:0] r;
        do_reset();
        access(32'h00, r);
        access(32'h10, r);
        compared++;
        if (r !== EXP_MISS) begin mismatched++; $display("FAIL t4_0x10 got %b required %b", r, EXP_MISS); end
        check_counts("t4_two_sets", 0, 2, 0);
        access(32'h10, r);
        compared++;
        if (r !== EXP_HIT) begin mismatched++; $display("FAIL t4_0x10_again got %b required %b", r, EXP_HIT); end
    endtask

    task automatic test_back_to_back();
        int f0, u0;
        logic busy_mid;
        do_reset();
        f0 = found_seen; u0 = upd_seen;
        @(negedge clk);
        mem_addr = 32'h00; trace_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) busy_mid = busy;
        end
        @(negedge clk);
        trace_ready = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (busy_mid !== 1'b1) begin mismatched++; $display("FAIL t5_busy got %b required 1", busy_mid); end
        compared++;
        if ((found_seen - f0) != 1 || (upd_seen - u0) != 1) begin
            mismatched++;
            $display("FAIL t5_pulses got hit=%0d upd=%0d required 1/1", found_seen - f0, upd_seen - u0);
        end
        check_counts("t5_counts", 1, 1, 0);
    endtask

    task automatic test_flush_and_reset();
        logic [5:0] r;
        int p0;
        do_reset();
        access(32'h00, r);
        p0 = found_seen + upd_seen;
        @(negedge clk);
        flush = 1'b1; trace_ready = 1'b1; mem_addr = 32'h00;
        @(negedge clk);
        flush = 1'b0; trace_ready = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if ((found_seen + upd_seen) != p0) begin mismatched++; $display("FAIL t6_flush_no_req got %0d pulses required 0", found_seen + upd_seen - p0); end
        access(32'h00, r);
        compared++;
        if (r !== EXP_MISS) begin mismatched++; $display("FAIL t6_after_flush got %b required %b", r, EXP_MISS); end
        check_counts("t6_flush_counts", 0, 2, 0);
        @(negedge clk);
        mem_addr = 32'h10; trace_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trace_ready = 1'b0;
        p0 = found_seen + upd_seen;
        rst_n = 1'b0;
        #1;
        check_counts("t6_reset_counts", 0, 0, 0);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL t6_reset_busy got %b required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if ((found_seen + upd_seen) != p0) begin mismatched++; $display("FAIL t6_reset_no_pulse got %0d pulses required 0", found_seen + upd_seen - p0); end
        access(32'h00, r);
        compared++;
        if (r !== EXP_MISS) begin mismatched++; $display("FAIL t6_after_reset got %b required %b", r, EXP_MISS); end
    endtask

    task automatic test_invariants();
        compared++;
        if (both_cnt != 0) begin mismatched++; $display("FAIL both_pulses got %0d required 0", both_cnt); end
        compared++;
        if (mono_err != 0) begin mismatched++; $display("FAIL monotonic got %0d drops required 0", mono_err); end
    endtask

    initial begin
        test_reset();
        test_hit_after_miss();
        test_eviction();
        test_lru_order();
        test_sets();
        test_back_to_back();
        test_flush_and_reset();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
